// File: rtl/hex_display_mmio.sv
// hex_display_mmio: memory-mapped hex display driver.
//   DATA at BASE_ADDR holds one nibble per digit, CTRL at BASE_ADDR+4 holds
//   EN (bit 0), BLINK (bit 1) and a per-digit BLANK mask (bits [8+N-1:8]).
//   Drives both a static segment bus (all digits at once) and a
//   time-multiplexed bus with a one-hot digit enable.
//   Optional feature macro: HEX_DISPLAY_BLINK_EN adds an 8-bit blink counter
//   clocked by the scan tick; without it BLINK reads 0 and never blanks.
module hex_display_mmio #(
  parameter int unsigned NUM_DIGITS = 2,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0014,
  parameter int unsigned SCAN_DIV   = 4096,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    MemWrite,
  input  logic [31:0]             Adr,
  input  logic [31:0]             WriteData,
  output logic [31:0]             rdata_o,
  output logic                    hit_o,
  output logic [7*NUM_DIGITS-1:0] seg_o,
  output logic [6:0]              seg_mux_o,
  output logic [NUM_DIGITS-1:0]   dig_en_o
);

  localparam int unsigned DW = 4 * NUM_DIGITS;
  localparam int unsigned SEGW = 7 * NUM_DIGITS;
  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned SW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [31:0] CTRL_ADDR = BASE_ADDR + 32'd4;
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] SCAN_MAX = SW'(NUM_DIGITS - 1);

  // Reject illegal configurations at elaboration time.
  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
    $error("hex_display_mmio: NUM_DIGITS must be 1..8");
  end
  if (SCAN_DIV < 2 || SCAN_DIV > (1 << 20)) begin : g_bad_div
    $error("hex_display_mmio: SCAN_DIV must be 2..2^20");
  end

  // Standard seven-segment patterns {G,F,E,D,C,B,A}, 1 = lit.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // ---------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------
  logic sel_data, sel_ctrl, wr_data, wr_ctrl;

  assign sel_data = (Adr == BASE_ADDR);
  assign sel_ctrl = (Adr == CTRL_ADDR);
  assign wr_data  = MemWrite && sel_data;
  assign wr_ctrl  = MemWrite && sel_ctrl;
  assign hit_o    = sel_data || sel_ctrl;

  // Only the low bits of WriteData are stored; fold the rest away so the
  // port is visibly consumed in every configuration.
  logic unused_wdata;
  assign unused_wdata = ^WriteData;

  // ---------------------------------------------------------------------
  // DATA / CTRL registers
  // ---------------------------------------------------------------------
  logic [DW-1:0]         data_q, data_d;
  logic                  en_q, en_d;
  logic [NUM_DIGITS-1:0] blank_q, blank_d;

  // Next-state for the software-visible registers.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    data_d  = data_q;
    en_d    = en_q;
    blank_d = blank_q;
    if (wr_data) begin
      data_d = WriteData[DW-1:0];
    end
    if (wr_ctrl) begin
      en_d    = WriteData[0];
      blank_d = WriteData[8 +: NUM_DIGITS];
    end
  end

  // Register state; reset leaves the display enabled showing zeros.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so all flops
      // sample pre-edge values regardless of statement order.
      data_q  <= '0;
      en_q    <= 1'b1;
      blank_q <= '0;
    end else begin
      data_q  <= data_d;
      en_q    <= en_d;
      blank_q <= blank_d;
    end
  end

  // ---------------------------------------------------------------------
  // Prescaler and scan index
  // ---------------------------------------------------------------------
  logic [PW-1:0] presc_q, presc_d;
  logic [SW-1:0] scan_q, scan_d;
  logic          tick;

  // The tick is the last prescaler count; while disabled nothing counts,
  // which also makes an EN 0->1 restart at digit 0 with prescaler 0.
  assign tick = en_q && (presc_q == PRESC_MAX);

  // Next-state for prescaler and scan index.
  always_comb begin
    presc_d = presc_q;
    scan_d  = scan_q;
    if (!en_q) begin
      presc_d = '0;
      scan_d  = '0;
    end else if (tick) begin
      presc_d = '0;
      scan_d  = (scan_q == SCAN_MAX) ? '0 : scan_q + SW'(1);
    end else begin
      presc_d = presc_q + PW'(1);
    end
  end

  // Prescaler and scan index registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
      scan_q  <= '0;
    end else begin
      presc_q <= presc_d;
      scan_q  <= scan_d;
    end
  end

  // ---------------------------------------------------------------------
  // Optional blink
  // ---------------------------------------------------------------------
  logic blink_bit;
  logic blink_dark;

`ifdef HEX_DISPLAY_BLINK_EN
  logic       blink_q, blink_d;
  logic [7:0] blink_cnt_q, blink_cnt_d;

  // BLINK control bit and a free-running tick counter whose MSB is the phase.
  always_comb begin
    blink_d     = blink_q;
    blink_cnt_d = blink_cnt_q;
    if (wr_ctrl) begin
      blink_d = WriteData[1];
    end
    if (tick) begin
      blink_cnt_d = blink_cnt_q + 8'd1;
    end
  end

  // Blink registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_q     <= 1'b0;
      blink_cnt_q <= '0;
    end else begin
      blink_q     <= blink_d;
      blink_cnt_q <= blink_cnt_d;
    end
  end

  assign blink_bit  = blink_q;
  assign blink_dark = blink_q && blink_cnt_q[7];
`else
  assign blink_bit  = 1'b0;
  assign blink_dark = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Readback
  // ---------------------------------------------------------------------
  logic [31:0] ctrl_word;

  // Assemble CTRL and select the readback word for the current address.
  always_comb begin
    ctrl_word                   = '0;
    ctrl_word[0]                = en_q;
    ctrl_word[1]                = blink_bit;
    ctrl_word[8 +: NUM_DIGITS]  = blank_q;
    rdata_o                     = '0;
    if (sel_data) begin
      rdata_o = 32'(data_q);
    end else if (sel_ctrl) begin
      rdata_o = ctrl_word;
    end
  end

  // ---------------------------------------------------------------------
  // Segment generation (logical polarity, 1 = lit / enabled)
  // ---------------------------------------------------------------------
  logic [SEGW-1:0]       seg_l;
  logic [6:0]            mux_l;
  logic [NUM_DIGITS-1:0] dig_l;

  // Decode each digit, darken it when disabled/blanked/blink-off, and pick
  // the scanned digit for the multiplexed bus.
  always_comb begin
    seg_l = '0;
    mux_l = '0;
    dig_l = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (en_q && !blank_q[i] && !blink_dark) begin
        seg_l[7*i +: 7] = hex7(data_q[4*i +: 4]);
      end
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (scan_q == SW'(i)) begin
        mux_l    = seg_l[7*i +: 7];
        dig_l[i] = en_q;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Output registers and pin polarity
  // ---------------------------------------------------------------------
  logic [SEGW-1:0]       seg_q;
  logic [6:0]            mux_q;
  logic [NUM_DIGITS-1:0] dig_q;

  // Register the pins so they change one edge after the register state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg_q <= '0;
      mux_q <= '0;
      dig_q <= '0;
    end else begin
      seg_q <= seg_l;
      mux_q <= mux_l;
      dig_q <= dig_l;
    end
  end

  assign seg_o     = ACTIVE_LOW ? ~seg_q : seg_q;
  assign seg_mux_o = ACTIVE_LOW ? ~mux_q : mux_q;
  assign dig_en_o  = ACTIVE_LOW ? ~dig_q : dig_q;

endmodule
